sync_fifo8: RTL

- Single-clock 8-bit FIFO that buffers the registered byte stream and write strobe from the upstream capture stage.
- Absorbs rate mismatch between that stage and the downstream consumer.
- Provides full/empty status, occupancy count, programmable almost-flags and error pulses.
- All state is in the clk domain.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mem_1r1w.sv | 30 +++
 rtl/sync_fifo8.sv | 96 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the byte FIFO and the stage that consumes its status.
package fifo_pkg;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;

  typedef logic [FIFO_DATA_W-1:0] byte_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;
endpackage

// File: rtl/fifo_mem_1r1w.sv
// DEPTH x DATA_W storage with a synchronous write port and a registered read port.
module fifo_mem_1r1w #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read samples the old contents, so a same-address write returns the stored entry.
  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo8.sv
// Single-clock byte FIFO between the capture stage and its downstream consumer,
// with occupancy count, almost-flags and registered overflow/underflow pulses.
module sync_fifo8
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] CNT_AE   = (ADDR_W+1)'(AE_LEVEL);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, underflow_q;
  logic              wr_acc, rd_acc;
  fifo_status_t      status;

  always_comb begin
    status.full         = (count_q == CNT_FULL);
    status.empty        = (count_q == '0);
    status.almost_full  = (count_q >= CNT_AF);
    status.almost_empty = (count_q <= CNT_AE);
  end

  // A write into a full FIFO is only taken when a read frees a slot in the same cycle.
  assign rd_acc = rd_en && !status.empty;
  assign wr_acc = wr_en && (!status.full || rd_en);

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= wr_en && status.full && !rd_en;
      underflow_q <= rd_en && status.empty;
    end
  end

  fifo_mem_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
endmodule
